// File: rtl/accumulator_bank_8.sv
// rtl/accumulator_bank_8.sv - eight-neuron saturating current accumulator bank with snapshot output stream
module accumulator_bank_8 #(
   parameter int ACC_W = 16,
   parameter int W_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [8*W_W-1:0]   w_data,
   input  logic               spk_in,
   input  logic               acc_en,
   input  logic               cntrl_ac_reset,
   input  logic               cntrl_ac_oen,
   output logic [ACC_W-1:0]   ac_out,
   output logic [2:0]         ac_out_idx,
   output logic               ac_out_valid,
   output logic               overrun
);

   typedef enum logic {IDLE, STREAM} state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic               hit_d;
   logic [ACC_W-1:0]   acc      [8];
   logic [ACC_W-1:0]   acc_next [8];
   logic [ACC_W-1:0]   snapshot [8];
   logic [ACC_W:0]     sum      [8];

   state_t             state, state_n;
   logic [2:0]         idx, idx_n;
   logic               overrun_n;

   // Per-lane sum one bit wider than the accumulator, clamped on signed overflow.
   // acc_next is what acc becomes at this edge, ignoring a layer clear.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         sum[i] = {acc[i][ACC_W-1], acc[i]}
                + {{(ACC_W+1-W_W){w_data[i*W_W+W_W-1]}}, w_data[i*W_W +: W_W]};
         if (!hit_d)
            acc_next[i] = acc[i];
         else if (sum[i][ACC_W] != sum[i][ACC_W-1])
            acc_next[i] = sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
         else
            acc_next[i] = sum[i][ACC_W-1:0];
      end
   end

   // Hit pipeline aligned to SRAM read latency; accumulators with layer clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_d <= 1'b0;
         for (int i = 0; i < 8; i++) acc[i] <= '0;
      end else begin
         hit_d <= spk_in & acc_en & ~cntrl_ac_reset;
         for (int i = 0; i < 8; i++) acc[i] <= cntrl_ac_reset ? '0 : acc_next[i];
      end
   end

   // Snapshot captures the post-accumulation value so a clear on the same edge loses nothing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) snapshot[i] <= '0;
      end else if (cntrl_ac_oen) begin
         for (int i = 0; i < 8; i++) snapshot[i] <= acc_next[i];
      end
   end

   // Output FSM state, beat index and sticky overrun flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= 3'd0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         overrun <= overrun_n;
      end
   end

   // Next-state logic: a new oen restarts the stream; only mid-stream restarts flag overrun.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      overrun_n = overrun;
      case (state)
         IDLE: begin
            if (cntrl_ac_oen) begin
               state_n = STREAM;
               idx_n   = 3'd0;
            end
         end
         STREAM: begin
            if (cntrl_ac_oen) begin
               idx_n = 3'd0;
               if (idx != 3'd7) overrun_n = 1'b1;
            end else if (idx == 3'd7) begin
               state_n = IDLE;
               idx_n   = 3'd0;
            end else begin
               idx_n = idx + 3'd1;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from state so an asynchronous reset drops valid immediately.
   always_comb begin
      ac_out_valid = (state == STREAM);
      ac_out_idx   = ac_out_valid ? idx : 3'd0;
      ac_out       = ac_out_valid ? snapshot[idx] : '0;
   end

endmodule

// File: tb/tb_accumulator_bank_8.sv
// tb/tb_accumulator_bank_8.sv - directed self-checking bench for accumulator_bank_8
module tb_accumulator_bank_8;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] w_data;
   logic        spk_in, acc_en, cntrl_ac_reset, cntrl_ac_oen;
   logic [15:0] ac_out;
   logic [2:0]  ac_out_idx;
   logic        ac_out_valid, overrun;

   int tests = 0;
   int fails = 0;

   logic [19:0] cap     [20];
   logic        cap_ovr [20];

   accumulator_bank_8 #(.ACC_W(16), .W_W(8)) dut (
      .clk(clk), .reset(reset), .w_data(w_data), .spk_in(spk_in), .acc_en(acc_en),
      .cntrl_ac_reset(cntrl_ac_reset), .cntrl_ac_oen(cntrl_ac_oen),
      .ac_out(ac_out), .ac_out_idx(ac_out_idx), .ac_out_valid(ac_out_valid), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Tasks start and end on a falling edge; outputs are sampled there.
   task automatic apply_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_acc();
      cntrl_ac_reset = 1'b1;
      @(negedge clk);
      cntrl_ac_reset = 1'b0;
   endtask

   task automatic rows(input int n, input logic s, input logic e, input logic [63:0] word);
      w_data = word;
      spk_in = s;
      acc_en = e;
      repeat (n) @(negedge clk);
      spk_in = 1'b0;
      acc_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_oen();
      cntrl_ac_oen = 1'b1;
      @(negedge clk);
      cntrl_ac_oen = 1'b0;
   endtask

   task automatic capture(input int n, input int oen_at);
      for (int k = 0; k < n; k++) begin
         cap[k]       = {ac_out_valid, ac_out_idx, ac_out};
         cap_ovr[k]   = overrun;
         cntrl_ac_oen = (k == oen_at);
         @(negedge clk);
      end
      cntrl_ac_oen = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      w_data = '0; spk_in = 0; acc_en = 0; cntrl_ac_reset = 0; cntrl_ac_oen = 0;
      #1;
      tests++;
      if ({ac_out_valid, ac_out_idx, ac_out} !== 20'h0) begin
         fails++;
         $display("FAIL reset_outputs got %h want 00000", {ac_out_valid, ac_out_idx, ac_out});
      end
      tests++;
      if (overrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_overrun got %b want 0", overrun);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (ac_out_valid !== 1'b0) begin
         fails++;
         $display("FAIL idle_valid got %b want 0", ac_out_valid);
      end
   endtask

   task automatic test_basic();
      rows(3, 1'b1, 1'b1, {8{8'd5}});
      start_oen();
      capture(10, -1);
      for (int k = 0; k < 10; k++) begin
         logic [19:0] exp;
         exp = (k < 8) ? {1'b1, 3'(k), 16'd15} : 20'h0;
         tests++;
         if (cap[k] !== exp) begin
            fails++;
            $display("FAIL basic_beat%0d got %h want %h", k, cap[k], exp);
         end
      end
   endtask

   task automatic test_gated();
      rows(2, 1'b1, 1'b0, {8{8'd100}});
      rows(2, 1'b0, 1'b1, {8{8'd100}});
      start_oen();
      capture(9, -1);
      for (int k = 0; k < 9; k++) begin
         logic [19:0] exp;
         exp = (k < 8) ? {1'b1, 3'(k), 16'd15} : 20'h0;
         tests++;
         if (cap[k] !== exp) begin
            fails++;
            $display("FAIL gated_beat%0d got %h want %h", k, cap[k], exp);
         end
      end
   endtask

   task automatic test_saturate();
      clear_acc();
      rows(300, 1'b1, 1'b1, {48'h0, 8'h80, 8'h7F});
      start_oen();
      capture(9, -1);
      for (int k = 0; k < 9; k++) begin
         logic [19:0] exp;
         if (k == 0)      exp = {1'b1, 3'd0, 16'h7FFF};
         else if (k == 1) exp = {1'b1, 3'd1, 16'h8000};
         else if (k < 8)  exp = {1'b1, 3'(k), 16'h0000};
         else             exp = 20'h0;
         tests++;
         if (cap[k] !== exp) begin
            fails++;
            $display("FAIL saturate_beat%0d got %h want %h", k, cap[k], exp);
         end
      end
   endtask

   task automatic test_oen_with_clear();
      clear_acc();
      rows(1, 1'b1, 1'b1, {8{8'd3}});
      w_data = {8{8'd2}};
      spk_in = 1'b1;
      acc_en = 1'b1;
      @(negedge clk);
      spk_in = 1'b0;
      acc_en = 1'b0;
      cntrl_ac_oen = 1'b1;
      cntrl_ac_reset = 1'b1;
      @(negedge clk);
      cntrl_ac_oen = 1'b0;
      cntrl_ac_reset = 1'b0;
      capture(9, -1);
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (cap[k] !== {1'b1, 3'(k), 16'd5}) begin
            fails++;
            $display("FAIL oenclr_beat%0d got %h want %h", k, cap[k], {1'b1, 3'(k), 16'd5});
         end
      end
      start_oen();
      capture(9, -1);
      for (int k = 0; k < 9; k++) begin
         logic [19:0] exp;
         exp = (k < 8) ? {1'b1, 3'(k), 16'd0} : 20'h0;
         tests++;
         if (cap[k] !== exp) begin
            fails++;
            $display("FAIL cleared_beat%0d got %h want %h", k, cap[k], exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      rows(1, 1'b1, 1'b1, {8{8'd7}});
      start_oen();
      capture(17, 7);
      for (int k = 0; k < 17; k++) begin
         logic [19:0] exp;
         exp = (k < 16) ? {1'b1, 3'(k % 8), 16'd7} : 20'h0;
         tests++;
         if (cap[k] !== exp || cap_ovr[k] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_beat%0d got %h ovr %b want %h ovr 0", k, cap[k], cap_ovr[k], exp);
         end
      end
   endtask

   task automatic test_overrun();
      apply_reset();
      w_data = {8{8'd1}};
      spk_in = 1'b1;
      acc_en = 1'b1;
      cntrl_ac_oen = 1'b1;
      @(negedge clk);
      spk_in = 1'b0;
      acc_en = 1'b0;
      cntrl_ac_oen = 1'b0;
      capture(13, 3);
      for (int k = 0; k < 13; k++) begin
         logic [19:0] exp;
         logic        eo;
         if (k < 4)       exp = {1'b1, 3'(k), 16'd0};
         else if (k < 12) exp = {1'b1, 3'(k - 4), 16'd1};
         else             exp = 20'h0;
         eo = (k >= 4);
         tests++;
         if (cap[k] !== exp || cap_ovr[k] !== eo) begin
            fails++;
            $display("FAIL overrun_beat%0d got %h ovr %b want %h ovr %b", k, cap[k], cap_ovr[k], exp, eo);
         end
      end
      repeat (3) @(negedge clk);
      tests++;
      if (overrun !== 1'b1) begin
         fails++;
         $display("FAIL overrun_sticky got %b want 1", overrun);
      end
   endtask

   task automatic test_reset_mid_stream();
      rows(1, 1'b1, 1'b1, {8{8'd9}});
      start_oen();
      capture(4, -1);
      tests++;
      if ({ac_out_valid, ac_out_idx} !== 4'b1_100) begin
         fails++;
         $display("FAIL pre_reset_idx got %b want 1100", {ac_out_valid, ac_out_idx});
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({ac_out_valid, ac_out_idx, ac_out, overrun} !== 21'h0) begin
         fails++;
         $display("FAIL async_reset got %h want 000000", {ac_out_valid, ac_out_idx, ac_out, overrun});
      end
      @(negedge clk);
      reset = 1'b0;
      capture(4, -1);
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (cap[k] !== 20'h0) begin
            fails++;
            $display("FAIL post_reset_idle%0d got %h want 00000", k, cap[k]);
         end
      end
      start_oen();
      capture(9, -1);
      for (int k = 0; k < 9; k++) begin
         logic [19:0] exp;
         exp = (k < 8) ? {1'b1, 3'(k), 16'd0} : 20'h0;
         tests++;
         if (cap[k] !== exp) begin
            fails++;
            $display("FAIL post_reset_beat%0d got %h want %h", k, cap[k], exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gated();
      test_saturate();
      test_oen_with_clear();
      test_back_to_back();
      test_overrun();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/accumulator_bank_8.md
ACCUMULATOR_BANK_8 -- requirements
Module: accumulator_bank_8

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator and output width in bits.
REQ-002 SHALL have parameter W_W, default 8, per-neuron signed weight width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high; one clock, reset asynchronous active-high.
REQ-005 SHALL have port w_data  input  8*W_W  weight SRAM read word; lane i (bits i*W_W+:W_W) is the signed weight for neuron i.
REQ-006 SHALL have port spk_in  input  1  presynaptic spike for the current weight-row address.
REQ-007 SHALL have port acc_en  input  1  row-valid qualifier issued alongside the weight address.
REQ-008 SHALL have port cntrl_ac_reset  input  1  clear all accumulators (layer change).
REQ-009 SHALL have port cntrl_ac_oen  input  1  snapshot accumulators and start the output stream.
REQ-010 SHALL have port ac_out  output  ACC_W  signed accumulated current for neuron ac_out_idx.
REQ-011 SHALL have port ac_out_idx  output  3  neuron index of ac_out.
REQ-012 SHALL have port ac_out_valid  output  1  ac_out/ac_out_idx valid.
REQ-013 SHALL have port overrun  output  1  sticky: cntrl_ac_oen arrived while a stream was in progress.

Function
REQ-014 SHALL delay spk_in and acc_en by one register stage (hit_d = spk_in & acc_en) to align with the 1-cycle SRAM read latency; w_data is sampled one cycle after its address.
REQ-015 SHALL, on each edge where hit_d=1, add each lane's sign-extended weight to acc[i] for all 8 neurons in parallel.
REQ-016 SHALL compute each sum at ACC_W+1 bits and saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap-around.
REQ-017 SHALL leave acc[] unchanged on edges where hit_d=0.
REQ-018 SHALL, on an edge with cntrl_ac_reset=1, load acc[] with 0 and clear hit_d (pending accumulation squashed).
REQ-019 SHALL, on an edge with cntrl_ac_oen=1, load snapshot[i] with the value acc[i] would take at that edge ignoring cntrl_ac_reset (pending hit_d accumulation included).
REQ-020 SHALL, when cntrl_ac_oen and cntrl_ac_reset are both 1 on one edge, snapshot per REQ-019 and then clear acc[] per REQ-018; no contribution is lost.
REQ-021 SHALL implement output FSM states IDLE and STREAM; IDLE->STREAM on cntrl_ac_oen; STREAM holds 8 cycles with idx 0..7; STREAM->IDLE after idx 7 unless cntrl_ac_oen is asserted on that edge.
REQ-022 SHALL drive ac_out_valid=1 exactly in STREAM, starting the cycle after the cntrl_ac_oen edge, with ac_out=snapshot[ac_out_idx].
REQ-023 SHALL drive ac_out=0, ac_out_idx=0, ac_out_valid=0 in IDLE.
REQ-024 SHALL, on cntrl_ac_oen during STREAM with idx<7, reload snapshot, restart at idx 0 and set overrun; at idx 7 restart back-to-back without setting overrun.
REQ-025 SHALL clear overrun only on reset.
REQ-026 SHALL continue accumulating (REQ-015) independently of the output FSM.

Reset
REQ-027 SHALL, while reset=1, asynchronously force acc[]=0, snapshot[]=0, hit_d=0, FSM=IDLE, ac_out=0, ac_out_idx=0, ac_out_valid=0, overrun=0.
REQ-028 SHALL, on reset asserted mid-STREAM, abort the stream immediately with no further valid beats after deassertion.

Verification
REQ-029 SHALL cover: reset; 3 rows spk_in=1,acc_en=1, all lanes w=+5; then oen -> 8 beats idx 0..7, each ac_out=15, valid exactly 8 cycles.
REQ-030 SHALL cover: row with spk_in=0 or acc_en=0, w=+100 -> acc unchanged; subsequent stream shows prior values.
REQ-031 SHALL cover: lane 0 w=+127 for 300 hits, lane 1 w=-128 for 300 hits -> ac_out 32767 and -32768 (saturated, no wrap).
REQ-032 SHALL cover: last hit row (w=+2) with oen and ac_reset together on its commit edge -> stream includes +2; next stream after oen with no hits shows 0.
REQ-033 SHALL cover: oen at stream idx 3 -> restart at idx 0 with new snapshot, overrun=1 until reset; oen at idx 7 -> 16 contiguous valid beats, overrun stays 0.
REQ-034 SHALL cover: reset asserted at idx 4 -> ac_out_valid=0 same cycle, all accumulators 0 after release.
